// File: rtl/pll_sequencer.sv
// PLL power-up / lock qualification sequencer on the SPI clock domain.
// Drives PLL powerdown, glitch-free image-buffer clock select and pixel-domain reset.
module pll_sequencer #(
    parameter int SYNC_STAGES           = 2,
    parameter int LOCK_STABLE_CYCLES    = 64,
    parameter int LOCK_TIMEOUT_CYCLES   = 65535,
    parameter int SWITCH_GAP_CYCLES     = 4,
    parameter int POWERDOWN_HOLD_CYCLES = 16
) (
    input  logic       spi_clock_in,
    input  logic       spi_reset_in,
    input  logic       pll_power_req_in,
    input  logic       buffer_read_req_in,
    input  logic       pll_locked_in,
    output logic       pll_powerdown_n_out,
    output logic       pll_locked_sync_out,
    output logic       buffer_clock_sel_out,
    output logic       buffer_clock_en_out,
    output logic       pixel_reset_out,
    output logic       lock_timeout_out,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_POWER_UP = 3'd1,
        S_STABLE   = 3'd2,
        S_RUN      = 3'd3,
        S_GAP_PRE  = 3'd4,
        S_GAP_POST = 3'd5,
        S_FAULT    = 3'd6
    } state_t;

    localparam logic [15:0] HOLD     = 16'(POWERDOWN_HOLD_CYCLES);
    localparam logic [15:0] TMO_LAST = 16'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [15:0] GAP_LAST = 16'(SWITCH_GAP_CYCLES - 1);
    // The POWER_UP cycle that first sees lock counts as the first locked cycle.
    localparam logic [15:0] STB_LAST = 16'((LOCK_STABLE_CYCLES >= 2) ? LOCK_STABLE_CYCLES - 2 : 0);

    logic [SYNC_STAGES-1:0] sync_q;
    state_t      state_q, state_d, dest_q, dest_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pwr_q, pwr_d, sel_q, sel_d, en_q, en_d;
    logic        prst_q, prst_d, tmo_q, tmo_d, nsel_q, nsel_d;
    logic        lock;

    assign lock = sync_q[SYNC_STAGES-1];

    always_ff @(posedge spi_clock_in or posedge spi_reset_in) begin
        if (spi_reset_in) begin
            sync_q  <= '0;
            state_q <= S_OFF;
            dest_q  <= S_OFF;
            cnt_q   <= '0;
            pwr_q   <= 1'b0;
            sel_q   <= 1'b1;
            en_q    <= 1'b1;
            prst_q  <= 1'b1;
            tmo_q   <= 1'b0;
            nsel_q  <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pll_locked_in};
            state_q <= state_d;
            dest_q  <= dest_d;
            cnt_q   <= cnt_d;
            pwr_q   <= pwr_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            prst_q  <= prst_d;
            tmo_q   <= tmo_d;
            nsel_q  <= nsel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        cnt_d   = cnt_q + 16'd1;
        pwr_d   = pwr_q;
        sel_d   = sel_q;
        en_d    = en_q;
        prst_d  = prst_q;
        tmo_d   = tmo_q;
        nsel_d  = nsel_q;
        case (state_q)
            S_OFF: begin
                cnt_d = (cnt_q < HOLD) ? cnt_q + 16'd1 : cnt_q;
                if (pll_power_req_in && cnt_q >= HOLD) begin
                    state_d = S_POWER_UP;
                    pwr_d   = 1'b1;
                    tmo_d   = 1'b0;
                end
            end
            S_POWER_UP: begin
                if (!pll_power_req_in) begin
                    state_d = S_OFF;
                    pwr_d   = 1'b0;
                end else if (lock) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_FAULT;
                    pwr_d   = 1'b0;
                    tmo_d   = 1'b1;
                end
            end
            S_STABLE: begin
                if (!pll_power_req_in) begin
                    state_d = S_OFF;
                    pwr_d   = 1'b0;
                end else if (!lock) begin
                    state_d = S_POWER_UP;
                end else if (cnt_q == STB_LAST) begin
                    state_d = S_RUN;
                    prst_d  = 1'b0;
                end
            end
            S_RUN: begin
                // prst_q high here means lock was lost during the gap that led back to RUN
                if (!lock || prst_q) begin
                    prst_d = 1'b1;
                    if (!sel_q) begin
                        state_d = S_GAP_PRE;
                        en_d    = 1'b0;
                        dest_d  = S_POWER_UP;
                        nsel_d  = 1'b1;
                    end else begin
                        state_d = S_POWER_UP;
                    end
                end else if (!pll_power_req_in) begin
                    prst_d = 1'b1;
                    if (!sel_q) begin
                        state_d = S_GAP_PRE;
                        en_d    = 1'b0;
                        dest_d  = S_OFF;
                        nsel_d  = 1'b1;
                    end else begin
                        state_d = S_OFF;
                        pwr_d   = 1'b0;
                    end
                end else if (buffer_read_req_in != sel_q) begin
                    state_d = S_GAP_PRE;
                    en_d    = 1'b0;
                    dest_d  = S_RUN;
                    nsel_d  = buffer_read_req_in;
                end
            end
            S_GAP_PRE: begin
                prst_d = prst_q | ~lock;
                if (cnt_q == GAP_LAST) begin
                    state_d = S_GAP_POST;
                    sel_d   = nsel_q;
                end
            end
            S_GAP_POST: begin
                prst_d = prst_q | ~lock;
                if (cnt_q == GAP_LAST) begin
                    state_d = dest_q;
                    en_d    = 1'b1;
                    if (dest_q == S_OFF) pwr_d = 1'b0;
                end
            end
            S_FAULT: begin
                if (!pll_power_req_in) state_d = S_OFF;
            end
            default: begin
                state_d = S_OFF;
                pwr_d   = 1'b0;
                sel_d   = 1'b1;
                en_d    = 1'b1;
                prst_d  = 1'b1;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    assign pll_powerdown_n_out  = pwr_q;
    assign pll_locked_sync_out  = lock;
    assign buffer_clock_sel_out = sel_q;
    assign buffer_clock_en_out  = en_q;
    assign pixel_reset_out      = prst_q;
    assign lock_timeout_out     = tmo_q;
    assign state_out            = state_q;

endmodule

// File: tb/tb_pll_sequencer.sv
// Directed bench for pll_sequencer: power-up, select gap, lock loss, glitch, timeout, async reset.
// Edge numbers in comments count rising edges after reset release (inputs change 1 ns after an edge).
module tb_pll_sequencer;

    logic       clk = 1'b0;
    logic       rst, req, breq, lock;
    logic       pwr, sync, sel, en, prst, tmo;
    logic [2:0] st;

    int total = 0;
    int bad = 0;
    int glitch = 0;
    logic sel_prev = 1'b1;
    logic en_prev = 1'b1;

    always #5 clk = ~clk;

    pll_sequencer #(
        .SYNC_STAGES(2),
        .LOCK_STABLE_CYCLES(64),
        .LOCK_TIMEOUT_CYCLES(1000),
        .SWITCH_GAP_CYCLES(4),
        .POWERDOWN_HOLD_CYCLES(16)
    ) dut (
        .spi_clock_in(clk),
        .spi_reset_in(rst),
        .pll_power_req_in(req),
        .buffer_read_req_in(breq),
        .pll_locked_in(lock),
        .pll_powerdown_n_out(pwr),
        .pll_locked_sync_out(sync),
        .buffer_clock_sel_out(sel),
        .buffer_clock_en_out(en),
        .pixel_reset_out(prst),
        .lock_timeout_out(tmo),
        .state_out(st)
    );

    // Counts any select edge that coincides with an enabled buffer clock.
    always @(negedge clk) begin
        if (!rst && (sel !== sel_prev) && (en || en_prev)) glitch <= glitch + 1;
        sel_prev <= sel;
        en_prev  <= en;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {pwr, sync, sel, en, prst, tmo, st};
    endfunction

    initial begin
        rst = 1'b1; req = 1'b0; breq = 1'b1; lock = 1'b0;
        tick(2);
        chk("reset_outputs", 32'(outs()), 32'({1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0}));

        // 1: power-up and lock qualification
        rst = 1'b0; req = 1'b1;
        tick(16);                                   // edge 16
        chk("hold_pwr_low", 32'(pwr), 32'd0);
        chk("hold_state_off", 32'(st), 32'd0);
        tick(1);                                    // edge 17
        chk("pwr_up_pwr", 32'(pwr), 32'd1);
        chk("pwr_up_state", 32'(st), 32'd1);
        tick(100);                                  // edge 117
        lock = 1'b1;
        tick(1);                                    // edge 118
        chk("sync_lat1", 32'(sync), 32'd0);
        tick(1);                                    // edge 119
        chk("sync_lat2", 32'(sync), 32'd1);
        tick(1);                                    // edge 120
        chk("stable_enter", 32'(st), 32'd2);
        tick(62);                                   // edge 182
        chk("stable_63_state", 32'(st), 32'd2);
        chk("stable_63_prst", 32'(prst), 32'd1);
        tick(1);                                    // edge 183 = 64 after synced lock
        chk("run_state", 32'(st), 32'd3);
        chk("run_prst", 32'(prst), 32'd0);
        chk("run_sel_en", 32'({sel, en}), 32'b11);

        // 2: select change SPI -> pixel clock
        breq = 1'b0;
        tick(1);                                    // edge 184
        chk("gap_pre_en", 32'({st, en, sel}), 32'({3'd4, 1'b0, 1'b1}));
        tick(3);                                    // edge 187
        chk("gap_pre_last", 32'({st, en, sel}), 32'({3'd4, 1'b0, 1'b1}));
        tick(1);                                    // edge 188
        chk("gap_post_sel", 32'({st, en, sel}), 32'({3'd5, 1'b0, 1'b0}));
        tick(3);                                    // edge 191
        chk("gap_post_last", 32'({st, en, sel}), 32'({3'd5, 1'b0, 1'b0}));
        tick(1);                                    // edge 192
        chk("gap_done", 32'({st, en, sel, prst}), 32'({3'd3, 1'b1, 1'b0, 1'b0}));

        // 3: lock loss in RUN with pixel clock selected
        lock = 1'b0;
        tick(2);                                    // edge 194
        chk("loss_sync", 32'({sync, prst, st}), 32'({1'b0, 1'b0, 3'd3}));
        tick(1);                                    // edge 195
        chk("loss_prst", 32'({prst, st, en, sel}), 32'({1'b1, 3'd4, 1'b0, 1'b0}));
        breq = 1'b1;                                // ignored during the gap
        tick(4);                                    // edge 199
        chk("loss_sel_forced", 32'({st, sel, en}), 32'({3'd5, 1'b1, 1'b0}));
        tick(4);                                    // edge 203
        chk("loss_pwr_up", 32'({st, sel, en, pwr, prst}), 32'({3'd1, 1'b1, 1'b1, 1'b1, 1'b1}));
        lock = 1'b1;
        tick(65);                                   // edge 268
        chk("relock_wait", 32'({st, prst}), 32'({3'd2, 1'b1}));
        tick(1);                                    // edge 269
        chk("relock_run", 32'({st, prst}), 32'({3'd3, 1'b0}));

        // 5: lock loss with SPI clock selected, then a one-cycle synced glitch in STABLE
        lock = 1'b0;
        tick(2);                                    // edge 271
        chk("loss2_hold", 32'({st, prst}), 32'({3'd3, 1'b0}));
        tick(1);                                    // edge 272
        chk("loss2_direct", 32'({st, prst, sel, en, pwr}), 32'({3'd1, 1'b1, 1'b1, 1'b1, 1'b1}));
        lock = 1'b1;
        tick(3);                                    // edge 275
        chk("glitch_stable", 32'(st), 32'd2);
        tick(49);                                   // edge 324
        lock = 1'b0;
        tick(1);                                    // edge 325
        lock = 1'b1;
        tick(1);                                    // edge 326
        chk("glitch_sync_low", 32'({sync, st}), 32'({1'b0, 3'd2}));
        tick(1);                                    // edge 327
        chk("glitch_back_pwrup", 32'(st), 32'd1);
        tick(1);                                    // edge 328
        chk("glitch_restable", 32'(st), 32'd2);
        tick(62);                                   // edge 390
        chk("glitch_count_restart", 32'({st, prst}), 32'({3'd2, 1'b1}));
        tick(1);                                    // edge 391
        chk("glitch_run", 32'({st, prst}), 32'({3'd3, 1'b0}));

        // 6: asynchronous reset in GAP_PRE
        breq = 1'b0;
        tick(2);                                    // edge 393
        chk("pre_reset_gap", 32'({st, en}), 32'({3'd4, 1'b0}));
        #3 rst = 1'b1; lock = 1'b0;
        #1 chk("async_reset", 32'(outs()), 32'({1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0}));

        // 4: lock timeout (edges recounted from this release)
        tick(1);
        rst = 1'b0; req = 1'b1; breq = 1'b1;
        tick(16);                                   // edge 16
        chk("to_hold", 32'({st, pwr}), 32'({3'd0, 1'b0}));
        tick(1);                                    // edge 17
        chk("to_pwr_up", 32'({st, pwr, tmo}), 32'({3'd1, 1'b1, 1'b0}));
        tick(999);                                  // edge 1016
        chk("to_still_up", 32'({st, tmo}), 32'({3'd1, 1'b0}));
        tick(1);                                    // edge 1017
        chk("to_fault", 32'({st, tmo, pwr, sel, en, prst}), 32'({3'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1}));
        req = 1'b0;
        tick(1);                                    // edge 1018
        chk("to_off_sticky", 32'({st, tmo}), 32'({3'd0, 1'b1}));
        req = 1'b1;
        tick(16);                                   // edge 1034
        chk("to_off_hold", 32'({st, tmo, pwr}), 32'({3'd0, 1'b1, 1'b0}));
        tick(1);                                    // edge 1035
        chk("to_repower_clear", 32'({st, tmo, pwr}), 32'({3'd1, 1'b0, 1'b1}));

        chk("no_sel_edge_while_en", 32'(glitch), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
